// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads 32-bit words from RAM and streams them out LSB byte first under txready flow control.
module mem_dump_tx #(
    parameter int ADDR_W    = 12,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        word_count,
    output logic              read_enable,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [31:0]       read_data,
    input  logic              txready,
    output logic [7:0]        txdata,
    output logic              txclk,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        remaining;
    logic [1:0]        byte_idx;
    logic [31:0]       word;
    logic              accept, last;
    assign accept      = (state == SEND) && txready;
    assign last        = accept && (byte_idx == 2'd3);
    assign read_enable = (state == READ);
    assign read_addr   = cur_addr;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (word_count != 8'd0) ? READ : DONE;
            READ:    state_n = CAPTURE;
            CAPTURE: state_n = SEND;
            SEND:    if (last) state_n = (remaining > 8'd1) ? READ : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            word      <= '0;
            txdata    <= '0;
            txclk     <= 1'b0;
        end else begin
            state <= state_n;
            txclk <= accept;
            if (state == IDLE && start && word_count != 8'd0) begin
                cur_addr  <= base_addr;
                remaining <= word_count;
            end
            if (state == CAPTURE) begin
                word     <= read_data;
                byte_idx <= '0;
            end
            if (accept) begin
                txdata   <= word[8*byte_idx +: 8];
                byte_idx <= byte_idx + 2'd1;
            end
            // Address wraps naturally at ADDR_W bits.
            if (last) begin
                remaining <= remaining - 8'd1;
                cur_addr  <= cur_addr + ADDR_W'(ADDR_STEP);
            end
        end
    end
endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: table-driven directed checks of mem_dump_tx against a behavioural RAM.
module tb_mem_dump_tx;
    logic        clk = 1'b0;
    logic        reset, start, txready;
    logic [11:0] base_addr;
    logic [7:0]  word_count;
    logic        read_enable;
    logic [11:0] read_addr;
    logic [31:0] read_data;
    logic [7:0]  txdata;
    logic        txclk, busy, done;
    int errors = 0;
    int checks = 0;
    logic [31:0] ram [0:1023];
    typedef struct {
        logic [11:0] base;
        logic [7:0]  cnt;
        int          st_lo, st_hi;
        bit          restart;
        int          done_cyc, first_tx, n_rd;
        logic [35:0] rds;
        int          n_by;
        logic [95:0] bytes;
    } vec_t;
    vec_t vecs [5];
    always #5 clk = ~clk;
    mem_dump_tx #(.ADDR_W(12), .ADDR_STEP(4)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .read_enable(read_enable), .read_addr(read_addr),
        .read_data(read_data), .txready(txready), .txdata(txdata), .txclk(txclk),
        .busy(busy), .done(done)
    );
    always @(posedge clk) if (read_enable) read_data <= ram[read_addr[11:2]];
    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic run_vec(input int i, input vec_t v);
        int got_done = -1, first_tx = -1, first_rd = -1, n_rd = 0, n_by = 0;
        logic [35:0] rds = '0;
        logic [95:0] by = '0;
        bit busy_ok = 1, strobe_ok = 1, prev_ready = 1;
        @(posedge clk); #1;
        start = 1; base_addr = v.base; word_count = v.cnt; txready = 1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (v.restart && c == 2) begin
                start = 1; base_addr = 12'h300; word_count = 8'd5;
            end else begin
                start = 0; base_addr = v.base; word_count = v.cnt;
            end
            if (read_enable) begin
                if (n_rd < 3) rds[n_rd*12 +: 12] = read_addr;
                if (first_rd < 0) first_rd = c;
                n_rd++;
            end
            if (txclk) begin
                if (!prev_ready) strobe_ok = 0;
                if (first_tx < 0) first_tx = c;
                if (n_by < 12) by[n_by*8 +: 8] = txdata;
                n_by++;
            end
            if (busy !== (c <= v.done_cyc)) busy_ok = 0;
            if (done === 1'b1 && got_done < 0) got_done = c;
            txready = !(c >= v.st_lo && c <= v.st_hi);
            prev_ready = txready;
            if (c > v.done_cyc) break;
        end
        start = 0; txready = 1;
        check($sformatf("v%0d done_cycle", i), got_done, v.done_cyc);
        check($sformatf("v%0d first_read_cycle", i), first_rd, (v.n_rd > 0) ? 1 : -1);
        check($sformatf("v%0d first_txclk_cycle", i), first_tx, v.first_tx);
        check($sformatf("v%0d read_count", i), n_rd, v.n_rd);
        check($sformatf("v%0d read_addrs", i), rds, v.rds);
        check($sformatf("v%0d byte_count", i), n_by, v.n_by);
        check($sformatf("v%0d bytes", i), by, v.bytes);
        check($sformatf("v%0d busy_profile", i), busy_ok, 1);
        check($sformatf("v%0d txclk_after_ready", i), strobe_ok, 1);
        for (int k = 0; k < 50 && busy; k++) begin
            @(posedge clk); #1;
        end
        check($sformatf("v%0d idle_after", i), busy, 0);
    endtask
    initial begin
        int strobes;
        for (int a = 0; a < 1024; a++) ram[a] = '0;
        ram[12'h010 >> 2] = 32'hDEADBEEF;
        ram[12'h100 >> 2] = 32'h00000001;
        ram[12'h104 >> 2] = 32'h00000002;
        ram[12'h108 >> 2] = 32'h00000003;
        ram[12'hFFC >> 2] = 32'h11223344;
        ram[0]            = 32'h55667788;
        vecs[0] = '{12'h010, 8'd1, 0, -1, 1'b0, 7,  4,  1, 36'h000000010, 4,  96'hDEADBEEF};
        vecs[1] = '{12'h100, 8'd3, 0, -1, 1'b1, 19, 4,  3, 36'h108104100, 12, 96'h000000030000000200000001};
        vecs[2] = '{12'h010, 8'd1, 3, 5,  1'b0, 10, 7,  1, 36'h000000010, 4,  96'hDEADBEEF};
        vecs[3] = '{12'hFFC, 8'd2, 0, -1, 1'b0, 13, 4,  2, 36'h000000FFC, 8,  96'h5566778811223344};
        vecs[4] = '{12'h010, 8'd0, 0, -1, 1'b0, 1,  -1, 0, 36'h0,         0,  96'h0};
        reset = 1; start = 0; txready = 1; base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset read_enable", read_enable, 0);
        check("reset read_addr", read_addr, 0);
        check("reset txdata", txdata, 0);
        check("reset txclk", txclk, 0);
        reset = 0;
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
        @(posedge clk); #1;
        reset = 1; start = 1; base_addr = 12'h010; word_count = 8'd1;
        @(posedge clk); #1;
        reset = 0; start = 0;
        check("rst_vs_start busy", busy, 0);
        check("rst_vs_start read_enable", read_enable, 0);
        @(posedge clk); #1;
        check("rst_vs_start busy later", busy, 0);
        start = 1; base_addr = 12'h010; word_count = 8'd1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 0;
        end
        check("mid txdata byte1", txdata, 8'hBE);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("mid busy", busy, 0);
        check("mid done", done, 0);
        check("mid txclk", txclk, 0);
        check("mid txdata", txdata, 0);
        check("mid read_addr", read_addr, 0);
        check("mid read_enable", read_enable, 0);
        strobes = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (txclk || busy) strobes++;
        end
        check("mid no activity", strobes, 0);
        run_vec(5, vecs[0]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 Parameter: ADDR_W, default 12, RAM data-address width.
REQ-002 Parameter: ADDR_STEP, default 4, byte-address increment per 32-bit word.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address, latched on accepted start.
REQ-007 word_count  input  8  number of words to dump, latched on accepted start.
REQ-008 read_enable  output  1  RAM data-port read strobe.
REQ-009 read_addr  output  ADDR_W  RAM data-port address.
REQ-010 read_data  input  32  RAM data-port output, valid the cycle after read_enable is high.
REQ-011 txready  input  1  byte sink can accept a byte this cycle.
REQ-012 txdata  output  8  byte to sink, registered.
REQ-013 txclk  output  1  one-cycle strobe, high when a new txdata byte is valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on completion.

Function
REQ-016 The FSM SHALL use states IDLE, READ, CAPTURE, SEND, DONE.
REQ-017 IDLE: start=1 with word_count!=0 SHALL latch base_addr into cur_addr and word_count into remaining, then go to READ.
REQ-018 IDLE: start=1 with word_count=0 SHALL go directly to DONE with no read_enable and no txclk.
REQ-019 READ (one cycle): read_enable=1 and read_addr=cur_addr; next state is CAPTURE.
REQ-020 CAPTURE (one cycle): word register SHALL load read_data at the closing edge; byte_idx<=0; next state is SEND.
REQ-021 SEND: txready=0 SHALL hold state, byte_idx and txdata unchanged.
REQ-022 SEND with txready=1 SHALL register txdata<=word[8*byte_idx+7 : 8*byte_idx], LSB byte first, with txclk<=1 the following cycle.
REQ-023 txclk SHALL be 0 in every cycle not immediately following an accepted SEND edge.
REQ-024 txdata SHALL hold its last value between strobes.
REQ-025 SEND with byte_idx<3 and txready=1 SHALL increment byte_idx and stay in SEND.
REQ-026 SEND with byte_idx=3 and txready=1 SHALL decrement remaining and add ADDR_STEP to cur_addr, modulo 2^ADDR_W (wraps 0xFFC->0x000 at defaults).
REQ-027 After REQ-026, next state SHALL be READ if remaining was >1, else DONE.
REQ-028 DONE (one cycle): done=1, busy=1; next state is IDLE.
REQ-029 start while busy SHALL be ignored; latched base and count SHALL be unaffected.
REQ-030 read_enable SHALL be 0 outside READ; read_addr SHALL equal cur_addr at all times.
REQ-031 Timing with txready held 1, start accepted at cycle 0:
- READ in cycle 1; CAPTURE in cycle 2.
- SEND in cycles 3-6; txclk high in cycles 4-7.
- The next word's READ, or DONE, falls in cycle 7.
- Each word costs 6 cycles.

Reset
REQ-032 reset=1 at a rising edge SHALL force IDLE regardless of state, including mid-dump.
REQ-033 Reset values: read_enable=0, read_addr=0, txdata=0x00, txclk=0, busy=0, done=0, cur_addr=0, remaining=0, byte_idx=0, word=0.
REQ-034 reset SHALL take priority over start in the same cycle.
REQ-035 No txclk pulse SHALL occur after the reset edge.

Verification
REQ-036 Single word, txready=1:
- Stimulus: base_addr=0x010, word_count=1; RAM[0x010]=0xDEADBEEF.
- Response: read_addr=0x010 in cycle 1; txclk cycles 4-7 carry bytes EF,BE,AD,DE; done in cycle 7; busy cycles 1-7.
REQ-037 Three words from base 0x100, RAM holds 0x00000001, 0x00000002, 0x00000003:
- Reads occur at 0x100, 0x104, 0x108.
- Byte stream is 01 00 00 00 02 00 00 00 03 00 00 00.
- done is in cycle 19.
REQ-038 Backpressure on the single-word case of REQ-036, txready=0 for cycles 3-5 then 1:
- No txclk while txready=0.
- Bytes are unchanged and in order.
- done is in cycle 10.
REQ-039 Wrap:
- Stimulus: base_addr=0xFFC, word_count=2.
- Response: reads at 0xFFC then 0x000.
REQ-040 word_count=0:
- No read_enable and no txclk.
- done is in cycle 1.
- A second start during an active dump is ignored.
REQ-041 Reset mid-dump:
- Stimulus: reset during SEND byte 2.
- Response: next cycle IDLE, all outputs at reset values, no further txclk.
- A fresh start then runs a complete dump correctly.
